psx_poll_sequencer: RTL and testbench
=====================================

Name: psx_poll_sequencer

Overview:
- Scheduler for a two-port PSX controller interface.
- Owns both attention lines.
- Drives a shared byte-level serial transceiver through a start/done handshake, one byte per exchange. The transceiver generates psx_clk/cmd and samples data/ack.
- Issues the poll sequence 0x01, 0x42, 0x00, 0x00, 0x00 to each enabled port in turn, validates the reply, and publishes per-port button words to the game logic.

Parameters:
- BOOT_TIME, 4000000: cycles idle after reset before the first poll.
- POLL_GAP, 32000: cycles in IDLE_GAP between poll rounds.
- ATT_SETUP, 16: cycles att_n is held low before the first byte.
- ATT_HOLD, 16: cycles after the last byte before att_n rises; also the att-high time before the next port.
- XFER_TIMEOUT, 200: maximum cycles from xfer_start to xfer_done before abort.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- port_en  input  2  per-port poll enable; sampled at the start of each round.
- poll_now  input  1  pulse; ends the current IDLE_GAP immediately.
- xfer_busy  input  1  transceiver busy.
- xfer_done  input  1  one-cycle pulse; byte exchange complete.
- xfer_rx  input  8  received byte; valid while xfer_done=1.
- xfer_ack_seen  input  1  controller ack observed during the byte; valid while xfer_done=1.
- xfer_start  output  1  one-cycle pulse; requests a byte exchange.
- xfer_tx  output  8  byte to send; held stable from xfer_start to xfer_done.
- att_n  output  2  per-port attention, active low.
- btn0  output  16  port 0 buttons {byte3, byte4}, active low.
- btn1  output  16  port 1 buttons, same format.
- pad_id0  output  8  last ID byte (byte1 reply) from port 0.
- pad_id1  output  8  last ID byte from port 1.
- present  output  2  port answered its last poll correctly.
- btn_upd  output  2  one-cycle pulse per port on a successful poll.

Behaviour:
- Reset values (asynchronous, immediate): att_n=2'b11, xfer_start=0, xfer_tx=8'hFF, btn0=btn1=16'hFFFF, pad_id0=pad_id1=8'hFF, present=0, btn_upd=0, state=BOOT, all counters 0.
- BOOT: count BOOT_TIME cycles, then go to IDLE_GAP with the gap counter preloaded to expire immediately. poll_now is ignored in BOOT.
- IDLE_GAP:
  - Count POLL_GAP cycles, or stop early if poll_now=1.
  - On exit, latch port_en into round_mask and select the lowest set bit.
  - If round_mask=0, restart IDLE_GAP.
- ATT_LOW: drive att_n[p]=0 for ATT_SETUP cycles. The other port's att_n stays 1; at most one att_n bit is low at any time.
- SEND:
  - Wait until xfer_busy=0.
  - Then assert xfer_start for exactly 1 cycle with xfer_tx=seq[idx], where idx runs 0..4 and seq={01,42,00,00,00}.
  - Go to WAIT_DONE.
- WAIT_DONE: wait for xfer_done, with a watchdog counter. On xfer_done:
  - idx1: store rx into an ID shadow register.
  - idx2: rx must be 8'h5A, else abort.
  - idx3: store rx into btn[15:8] shadow.
  - idx4: store rx into btn[7:0] shadow.
  - idx0..3: xfer_ack_seen=0 means abort. Ack is ignored on idx4.
  - If idx<4: idx++ and go to SEND. If idx=4: success and go to ATT_HIGH.
- Watchdog: after XFER_TIMEOUT cycles without xfer_done, abort.
- Success: in the cycle of leaving WAIT_DONE, copy the shadows to btnP and pad_idP, set present[p]=1, and pulse btn_upd[p].
- Abort:
  - present[p]=0 and btnP=16'hFFFF. pad_idP is unchanged.
  - No btn_upd pulse.
  - Go to ATT_HIGH.
  - A xfer_done arriving after a timeout abort is ignored.
- ATT_HIGH:
  - Hold att_n[p]=0 for ATT_HOLD cycles, then drive att_n=11.
  - Then hold att_n=11 for a further ATT_HOLD cycles.
  - Then go to the next set bit above p in round_mask, via ATT_LOW. If there is none, go to IDLE_GAP.
- Published outputs change only on success/abort; partial data is never visible.
- port_en changes mid-round take effect next round.
- poll_now arriving outside IDLE_GAP is dropped, not queued.
- xfer_done while not in WAIT_DONE is ignored.
- Reset mid-byte: att_n rises asynchronously. The transceiver is reset by the same rst_n.

Test Plan:
- Reset, port_en=01, BFM replies FF,41,5A,F7,FE with ack → after BOOT_TIME: att_n[0] low ATT_SETUP cycles; xfer_tx sequence 01,42,00,00,00; btn0=16'hF7FE, pad_id0=41, present=01, one btn_upd[0] pulse; att_n[1] never low.
- port_en=11, both ports valid with distinct data → port 0 then port 1 in one round; att_n never 2'b00; next round starts POLL_GAP cycles later; poll_now mid-gap starts the round next cycle.
- Port 1 BFM gives no ack on idx1 → abort after idx1; btn1=FFFF, present[1]=0, no btn_upd[1]; port 0 unaffected.
- Preamble reply 5B instead of 5A → abort; previous btn0 replaced by FFFF; present[0]=0.
- BFM withholds xfer_done → abort exactly XFER_TIMEOUT cycles after xfer_start; late xfer_done ignored; next round recovers.
- Assert rst_n=0 during WAIT_DONE of idx3 → att_n=11, outputs at reset values in the same cycle; BOOT restarts.

Source files
------------

// File: rtl/psx_poll_sequencer.sv
// Poll scheduler for a two-port PSX controller interface: owns both attention lines,
// sequences 01/42/00/00/00 through a byte transceiver and publishes validated button words.
module psx_poll_sequencer #(
  parameter int unsigned BOOT_TIME    = 4000000,
  parameter int unsigned POLL_GAP     = 32000,
  parameter int unsigned ATT_SETUP    = 16,
  parameter int unsigned ATT_HOLD     = 16,
  parameter int unsigned XFER_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  port_en,
  input  logic        poll_now,
  input  logic        xfer_busy,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rx,
  input  logic        xfer_ack_seen,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx,
  output logic [1:0]  att_n,
  output logic [15:0] btn0,
  output logic [15:0] btn1,
  output logic [7:0]  pad_id0,
  output logic [7:0]  pad_id1,
  output logic [1:0]  present,
  output logic [1:0]  btn_upd
);

  typedef enum logic [2:0] {
    S_BOOT, S_IDLE_GAP, S_ATT_LOW, S_SEND, S_WAIT_DONE, S_ATT_HIGH
  } state_e;

  localparam logic [31:0] BOOT_LAST  = 32'(BOOT_TIME - 1);
  localparam logic [31:0] GAP_LAST   = 32'(POLL_GAP - 1);
  localparam logic [31:0] SETUP_LAST = 32'(ATT_SETUP - 1);
  localparam logic [31:0] HOLD_N     = 32'(ATT_HOLD);
  localparam logic [31:0] HIGH_LAST  = 32'(2 * ATT_HOLD - 1);
  localparam logic [31:0] TO_LAST    = 32'(XFER_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        p_q, p_d;
  logic [1:0]  round_mask_q, round_mask_d;
  logic [7:0]  id_sh_q, id_sh_d;
  logic [7:0]  btn_hi_q, btn_hi_d;
  logic        xfer_start_q, xfer_start_d;
  logic [7:0]  xfer_tx_q, xfer_tx_d;
  logic [1:0]  att_n_q, att_n_d;
  logic [15:0] btn0_q, btn0_d, btn1_q, btn1_d;
  logic [7:0]  pad_id0_q, pad_id0_d, pad_id1_q, pad_id1_d;
  logic [1:0]  present_q, present_d;
  logic [1:0]  btn_upd_q, btn_upd_d;
  logic        end_poll, poll_ok;

  function automatic logic [7:0] seq_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h01;
      3'd1:    return 8'h42;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    p_d          = p_q;
    round_mask_d = round_mask_q;
    id_sh_d      = id_sh_q;
    btn_hi_d     = btn_hi_q;
    xfer_start_d = 1'b0;
    xfer_tx_d    = xfer_tx_q;
    btn0_d       = btn0_q;
    btn1_d       = btn1_q;
    pad_id0_d    = pad_id0_q;
    pad_id1_d    = pad_id1_q;
    present_d    = present_q;
    btn_upd_d    = 2'b00;
    end_poll     = 1'b0;
    poll_ok      = 1'b0;

    case (state_q)
      S_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = S_IDLE_GAP;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_IDLE_GAP: begin
        if (cnt_q >= GAP_LAST || poll_now) begin
          round_mask_d = port_en;
          cnt_d        = 32'd0;
          if (port_en != 2'b00) begin
            p_d     = ~port_en[0];
            state_d = S_ATT_LOW;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_ATT_LOW: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_SEND;
          idx_d   = 3'd0;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SEND: begin
        if (!xfer_busy) begin
          xfer_start_d = 1'b1;
          xfer_tx_d    = seq_byte(idx_q);
          state_d      = S_WAIT_DONE;
          cnt_d        = 32'd0;
        end
      end
      S_WAIT_DONE: begin
        if (xfer_done) begin
          if ((idx_q != 3'd4 && !xfer_ack_seen) || (idx_q == 3'd2 && xfer_rx != 8'h5A)) begin
            end_poll = 1'b1;
          end else begin
            if (idx_q == 3'd1) id_sh_d = xfer_rx;
            if (idx_q == 3'd3) btn_hi_d = xfer_rx;
            if (idx_q == 3'd4) begin
              end_poll = 1'b1;
              poll_ok  = 1'b1;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = S_SEND;
            end
          end
        end else if (cnt_q == TO_LAST) begin
          end_poll = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_ATT_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          cnt_d = 32'd0;
          if (!p_q && round_mask_q[1]) begin
            p_d     = 1'b1;
            state_d = S_ATT_LOW;
          end else begin
            state_d = S_IDLE_GAP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_BOOT;
    endcase

    // Published words move only here, so a half-read poll never reaches the game logic.
    if (end_poll) begin
      state_d        = S_ATT_HIGH;
      cnt_d          = 32'd0;
      present_d[p_q] = poll_ok;
      btn_upd_d[p_q] = poll_ok;
      if (!p_q) begin
        btn0_d = poll_ok ? {btn_hi_q, xfer_rx} : 16'hFFFF;
        if (poll_ok) pad_id0_d = id_sh_q;
      end else begin
        btn1_d = poll_ok ? {btn_hi_q, xfer_rx} : 16'hFFFF;
        if (poll_ok) pad_id1_d = id_sh_q;
      end
    end

    att_n_d = 2'b11;
    if (state_d inside {S_ATT_LOW, S_SEND, S_WAIT_DONE} ||
        (state_d == S_ATT_HIGH && cnt_d < HOLD_N)) begin
      att_n_d[p_d] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      cnt_q        <= 32'd0;
      idx_q        <= 3'd0;
      p_q          <= 1'b0;
      round_mask_q <= 2'b00;
      id_sh_q      <= 8'hFF;
      btn_hi_q     <= 8'hFF;
      xfer_start_q <= 1'b0;
      xfer_tx_q    <= 8'hFF;
      att_n_q      <= 2'b11;
      btn0_q       <= 16'hFFFF;
      btn1_q       <= 16'hFFFF;
      pad_id0_q    <= 8'hFF;
      pad_id1_q    <= 8'hFF;
      present_q    <= 2'b00;
      btn_upd_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      p_q          <= p_d;
      round_mask_q <= round_mask_d;
      id_sh_q      <= id_sh_d;
      btn_hi_q     <= btn_hi_d;
      xfer_start_q <= xfer_start_d;
      xfer_tx_q    <= xfer_tx_d;
      att_n_q      <= att_n_d;
      btn0_q       <= btn0_d;
      btn1_q       <= btn1_d;
      pad_id0_q    <= pad_id0_d;
      pad_id1_q    <= pad_id1_d;
      present_q    <= present_d;
      btn_upd_q    <= btn_upd_d;
    end
  end

  assign xfer_start = xfer_start_q;
  assign xfer_tx    = xfer_tx_q;
  assign att_n      = att_n_q;
  assign btn0       = btn0_q;
  assign btn1       = btn1_q;
  assign pad_id0    = pad_id0_q;
  assign pad_id1    = pad_id1_q;
  assign present    = present_q;
  assign btn_upd    = btn_upd_q;

endmodule

// File: tb/tb_psx_poll_sequencer.sv
// Directed bench for psx_poll_sequencer: a reactive transceiver/controller model plus
// a linear sequence of poll rounds with hand-computed expectations.
module tb_psx_poll_sequencer;

  localparam int BOOT_TIME    = 20;
  localparam int POLL_GAP     = 60;
  localparam int ATT_SETUP    = 4;
  localparam int ATT_HOLD     = 3;
  localparam int XFER_TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  port_en = 2'b00;
  logic        poll_now = 1'b0;
  logic        xfer_busy = 1'b0;
  logic        xfer_done = 1'b0;
  logic [7:0]  xfer_rx = 8'h00;
  logic        xfer_ack_seen = 1'b0;
  logic        xfer_start;
  logic [7:0]  xfer_tx;
  logic [1:0]  att_n;
  logic [15:0] btn0, btn1;
  logic [7:0]  pad_id0, pad_id1;
  logic [1:0]  present, btn_upd;

  psx_poll_sequencer #(
    .BOOT_TIME(BOOT_TIME), .POLL_GAP(POLL_GAP), .ATT_SETUP(ATT_SETUP),
    .ATT_HOLD(ATT_HOLD), .XFER_TIMEOUT(XFER_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .poll_now(poll_now),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .xfer_rx(xfer_rx),
    .xfer_ack_seen(xfer_ack_seen), .xfer_start(xfer_start), .xfer_tx(xfer_tx),
    .att_n(att_n), .btn0(btn0), .btn1(btn1), .pad_id0(pad_id0), .pad_id1(pad_id1),
    .present(present), .btn_upd(btn_upd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: per-port reply bytes, ack bits, and an optional byte whose done is withheld.
  logic [7:0] reply [2][5];
  logic       ack   [2][5];
  int         withhold_idx [2];
  int         withhold_start_cyc = 0;
  logic [7:0] tx_log [$];
  int         tx_cyc [$];
  int         bp = 0;
  int         bk = 0;

  task automatic set_port(input int p, input logic [7:0] id, input logic [7:0] pre,
                          input logic [7:0] hi, input logic [7:0] lo, input logic [4:0] ackm);
    reply[p][0] = 8'hFF;
    reply[p][1] = id;
    reply[p][2] = pre;
    reply[p][3] = hi;
    reply[p][4] = lo;
    for (int i = 0; i < 5; i++) ack[p][i] = ackm[i];
  endtask

  always begin
    @(posedge clk); #1;
    if (rst_n === 1'b1 && xfer_start === 1'b1) begin
      bp = (att_n === 2'b01) ? 1 : 0;
      bk = (xfer_tx === 8'h01) ? 0 : ((bk < 4) ? bk + 1 : 4);
      tx_log.push_back(xfer_tx);
      tx_cyc.push_back(cyc);
      xfer_busy = 1'b1;
      if (bk == withhold_idx[bp]) begin
        withhold_start_cyc = cyc;
        repeat (XFER_TIMEOUT + 3) @(posedge clk);
      end else begin
        repeat (3) @(posedge clk);
      end
      #1;
      xfer_rx       = reply[bp][bk];
      xfer_ack_seen = ack[bp][bk];
      xfer_done     = 1'b1;
      xfer_busy     = 1'b0;
      @(posedge clk); #1;
      xfer_done     = 1'b0;
      xfer_rx       = 8'h00;
      xfer_ack_seen = 1'b0;
    end
  end

  // Passive monitor of attention edges, update pulses and presence drops.
  int   att00_cnt = 0;
  int   att1_low_cnt = 0;
  int   upd_cnt [2] = '{0, 0};
  int   fall_cyc [2] = '{0, 0};
  int   last_rise_cyc = 0;
  int   gaps [$];
  int   pres0_fall_cyc = 0;
  logic [1:0] prev_att = 2'b11;
  logic prev_pres = 1'b0;

  always begin
    @(posedge clk); #1;
    if (att_n === 2'b00) att00_cnt++;
    if (att_n[1] === 1'b0) att1_low_cnt++;
    for (int p = 0; p < 2; p++) begin
      if (btn_upd[p] === 1'b1) upd_cnt[p]++;
      if (prev_att[p] === 1'b1 && att_n[p] === 1'b0) begin
        fall_cyc[p] = cyc;
        gaps.push_back(cyc - last_rise_cyc);
      end
      if (prev_att[p] === 1'b0 && att_n[p] === 1'b1) last_rise_cyc = cyc;
    end
    if (prev_pres === 1'b1 && present[0] === 1'b0) pres0_fall_cyc = cyc;
    prev_att  = att_n;
    prev_pres = present[0];
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_att_fall(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (att_n !== 2'b11) begin
        at = cyc;
        break;
      end
    end
  endtask

  // A round is over once both lines have been high for longer than the inter-port hold.
  task automatic wait_idle(input int budget, output logic ok);
    int run;
    run = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      run = (att_n === 2'b11) ? run + 1 : 0;
      if (run >= 8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_poll();
    poll_now = 1'b1;
    tick(1);
    poll_now = 1'b0;
  endtask

  logic [7:0] seq_exp [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};

  initial begin
    logic ok;
    int   at, r, n_gap, base_tx, u0, u1, a1;

    withhold_idx[0] = 5;
    withhold_idx[1] = 5;
    set_port(0, 8'h41, 8'h5A, 8'hF7, 8'hFE, 5'b11111);
    set_port(1, 8'h73, 8'h5A, 8'hAB, 8'hCD, 5'b01111);
    rst_n   = 1'b0;
    port_en = 2'b01;
    tick(3);
    check("rst_att_n", att_n, 2'b11);
    check("rst_xfer_start", xfer_start, 1'b0);
    check("rst_xfer_tx", xfer_tx, 8'hFF);
    check("rst_btn0", btn0, 16'hFFFF);
    check("rst_btn1", btn1, 16'hFFFF);
    check("rst_pad_id0", pad_id0, 8'hFF);
    check("rst_pad_id1", pad_id1, 8'hFF);
    check("rst_present", present, 2'b00);
    check("rst_btn_upd", btn_upd, 2'b00);

    // Round 1: port 0 only; poll_now during boot must not shorten it.
    rst_n = 1'b1;
    r = cyc;
    tick(3);
    pulse_poll();
    wait_att_fall(BOOT_TIME + 20, at);
    check("boot_to_first_att", at - r, BOOT_TIME + 1);
    check("r1_first_port", att_n, 2'b10);
    wait_idle(100, ok);
    check("r1_finished", ok, 1'b1);
    check("r1_tx_count", tx_log.size(), 5);
    for (int i = 0; i < 5; i++) check("r1_tx_seq", tx_log[i], seq_exp[i]);
    check("r1_att_setup", tx_cyc[0] - at, ATT_SETUP + 1);
    check("r1_btn0", btn0, 16'hF7FE);
    check("r1_pad_id0", pad_id0, 8'h41);
    check("r1_present", present, 2'b01);
    check("r1_upd0", upd_cnt[0], 1);
    check("r1_upd1", upd_cnt[1], 0);
    check("r1_att1_never_low", att1_low_cnt, 0);

    // Round 2: both ports, started by gap expiry; port 1 gives no ack on the last byte.
    port_en = 2'b11;
    set_port(0, 8'h41, 8'h5A, 8'h12, 8'h34, 5'b11111);
    n_gap = gaps.size();
    wait_att_fall(POLL_GAP + 20, at);
    wait_idle(150, ok);
    check("r2_finished", ok, 1'b1);
    check("r2_round_gap", gaps[n_gap], ATT_HOLD + POLL_GAP);
    check("r2_port_gap", gaps[n_gap + 1], ATT_HOLD);
    check("r2_port_order", fall_cyc[1] > fall_cyc[0], 1'b1);
    check("r2_btn0", btn0, 16'h1234);
    check("r2_btn1", btn1, 16'hABCD);
    check("r2_pad_id1", pad_id1, 8'h73);
    check("r2_present", present, 2'b11);
    check("r2_upd0", upd_cnt[0], 2);
    check("r2_upd1", upd_cnt[1], 1);
    check("r2_att_never_00", att00_cnt, 0);

    // Round 3: poll_now mid-gap; port 1 drops ack on idx1.
    set_port(0, 8'h41, 8'h5A, 8'h55, 8'hAA, 5'b11111);
    set_port(1, 8'h73, 8'h5A, 8'hAB, 8'hCD, 5'b11101);
    u0 = upd_cnt[0];
    u1 = upd_cnt[1];
    base_tx = tx_log.size();
    tick(5);
    pulse_poll();
    check("r3_poll_now_latency", att_n, 2'b10);
    wait_idle(150, ok);
    check("r3_finished", ok, 1'b1);
    check("r3_tx_count", tx_log.size() - base_tx, 7);
    check("r3_btn0", btn0, 16'h55AA);
    check("r3_btn1", btn1, 16'hFFFF);
    check("r3_present", present, 2'b01);
    check("r3_pad_id1", pad_id1, 8'h73);
    check("r3_upd0", upd_cnt[0] - u0, 1);
    check("r3_upd1", upd_cnt[1] - u1, 0);

    // Round 4: bad preamble on port 0; port_en widened mid-round must wait for the next round.
    port_en = 2'b01;
    set_port(0, 8'h44, 8'h5B, 8'h11, 8'h22, 5'b11111);
    u0 = upd_cnt[0];
    a1 = att1_low_cnt;
    tick(2);
    pulse_poll();
    tick(2);
    port_en = 2'b11;
    wait_idle(150, ok);
    port_en = 2'b01;
    check("r4_finished", ok, 1'b1);
    check("r4_btn0", btn0, 16'hFFFF);
    check("r4_present", present, 2'b00);
    check("r4_pad_id0", pad_id0, 8'h41);
    check("r4_upd0", upd_cnt[0] - u0, 0);
    check("r4_port1_skipped", att1_low_cnt - a1, 0);

    // Round 5a: valid poll so presence can be seen to drop.
    set_port(0, 8'h41, 8'h5A, 8'h13, 8'h57, 5'b11111);
    tick(2);
    pulse_poll();
    wait_idle(150, ok);
    check("r5a_btn0", btn0, 16'h1357);
    check("r5a_present", present, 2'b01);

    // Round 5b: done withheld on idx3, then delivered late.
    set_port(0, 8'h99, 8'h5A, 8'h66, 8'h77, 5'b11111);
    withhold_idx[0] = 3;
    u0 = upd_cnt[0];
    tick(2);
    pulse_poll();
    wait_idle(150, ok);
    withhold_idx[0] = 5;
    check("r5b_finished", ok, 1'b1);
    check("r5b_timeout_cycles", pres0_fall_cyc - withhold_start_cyc, XFER_TIMEOUT);
    check("r5b_btn0", btn0, 16'hFFFF);
    check("r5b_present", present, 2'b00);
    check("r5b_pad_id0", pad_id0, 8'h41);
    check("r5b_upd0", upd_cnt[0] - u0, 0);

    // Round 5c: recovery.
    set_port(0, 8'h41, 8'h5A, 8'h24, 8'h68, 5'b11111);
    u0 = upd_cnt[0];
    tick(2);
    pulse_poll();
    wait_idle(150, ok);
    check("r5c_btn0", btn0, 16'h2468);
    check("r5c_present", present, 2'b01);
    check("r5c_upd0", upd_cnt[0] - u0, 1);

    // Round 6: reset lands while idx3 is in flight.
    base_tx = tx_log.size();
    tick(2);
    pulse_poll();
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (tx_log.size() >= base_tx + 4) break;
    end
    check("r6_reached_idx3", tx_log.size() >= base_tx + 4, 1'b1);
    rst_n = 1'b0;
    #1;
    check("r6_rst_att_n", att_n, 2'b11);
    check("r6_rst_xfer_start", xfer_start, 1'b0);
    check("r6_rst_xfer_tx", xfer_tx, 8'hFF);
    check("r6_rst_btn0", btn0, 16'hFFFF);
    check("r6_rst_pad_id0", pad_id0, 8'hFF);
    check("r6_rst_present", present, 2'b00);
    check("r6_rst_btn_upd", btn_upd, 2'b00);
    tick(2);
    rst_n = 1'b1;
    r = cyc;
    wait_att_fall(BOOT_TIME + 20, at);
    check("r6_boot_restart", at - r, BOOT_TIME + 1);
    wait_idle(100, ok);
    check("r6_btn0", btn0, 16'h2468);
    check("r6_present", present, 2'b01);
    check("end_att_never_00", att00_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
